muldiv_unit: RTL and testbench

Parametrised, iterative multiply/divide unit that owns the HI/LO result register pair for the datapath. It takes over the multiply/divide work from the single-cycle ALU, so the ALU stays purely combinational. It takes two WIDTH-bit operands, runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles, and writes a 2*WIDTH-bit result into HI/LO. Control issues a one-cycle `start` and waits on `busy`/`done` before reading HI/LO for mfhi/mflo.

---
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply / restoring divide unit that owns
// the HI/LO result register pair.
//
// Every operation takes WIDTH iterations in RUN, then one FIX cycle. The
// result appears in HI/LO WIDTH+1 cycles after the edge that accepts start.
// This latency is the same for every operation type, including divide by
// zero.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high; clears all state
//   start     request pulse, sampled only while busy=0
//   op[1:0]   bit0: 0=mult, 1=div; bit1: 1=signed (MULDIV_SIGNED_EN only)
//   a, b      multiplicand/dividend and multiplier/divisor, sampled with start
//   busy      operation in progress
//   done      one-cycle pulse when HI/LO hold a new result
//   div_zero  sticky; set when the last div had b==0, cleared on accepted start
//   hi, lo    mult: product {hi,lo}; div: hi=remainder, lo=quotient
//
// Configuration macro: MULDIV_SIGNED_EN. When it is defined, op[1] selects
// signed operation. When it is undefined, every operation is unsigned.

module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  // opb holds the multiplicand (mult) or the divisor (div), always as a magnitude.
  logic [WIDTH-1:0]   opb;
  // acc is {upper, lower}. Mult: {partial product, multiplier}. Div: {rem, quot}.
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

`ifdef MULDIV_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q;  // negate product / quotient: the operand signs differ
  logic neg_r;  // negate remainder: it takes the dividend's sign
  assign a_neg = op[1] & a[WIDTH-1];
  assign b_neg = op[1] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
`else
  logic unused_op1;
  assign unused_op1 = op[1];
  assign a_mag      = a;
  assign b_mag      = b;
`endif

  // One iteration step for each operation.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    // NOTE: every always_comb output gets a default assignment first, so no path leaves it unassigned and infers a latch.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    // The shifted remainder needs one extra bit for the compare. The
    // difference always fits in WIDTH bits, because it is smaller than the divisor.
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_sub  = rem_sh[WIDTH-1:0] - opb;
    div_next = (rem_sh >= {1'b0, opb}) ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                                       : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Final result, formed during FIX.
  logic             divisor_zero;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign divisor_zero = (opb == '0);

  always_comb begin
    res_hi = acc[2*WIDTH-1:WIDTH];
    res_lo = acc[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (!is_div) begin
      if (neg_q) {res_hi, res_lo} = -acc;
    end else begin
      if (neg_q) res_lo = -acc[WIDTH-1:0];
      if (neg_r) res_hi = -acc[2*WIDTH-1:WIDTH];
    end
`endif
    // With a zero divisor every quotient bit is set and the remainder
    // is the dividend again, so hi=a needs no special handling. Forcing lo
    // to all ones also undoes any quotient sign negation.
    if (is_div && divisor_zero) res_lo = '1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      opb      <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div   <= op[0];
            opb      <= op[0] ? b_mag : a_mag;
            acc      <= {{WIDTH{1'b0}}, (op[0] ? a_mag : b_mag)};
            cnt      <= CNT_W'(WIDTH);
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
`ifdef MULDIV_SIGNED_EN
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
`endif
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          hi       <= res_hi;
          lo       <= res_lo;
          div_zero <= is_div & divisor_zero;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit.
// The WIDTH=32 instance runs a table of directed vectors, then randomized
// operations checked against an arithmetic model, then hand-written
// handshake and reset sequences.
// The WIDTH=8 instance checks an 8-bit product and its latency.

module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  logic         start8;
  logic [1:0]   op8;
  logic [7:0]   a8, b8;
  logic         busy8, done8, dz8;
  logic [7:0]   hi8, lo8;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] mh, output logic [W-1:0] ml, output logic mdz);
    logic        sgn;
    longint      sx, sy, q, r;
    logic [63:0] p;
    sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sgn = o[1];
`endif
    sx  = sgn ? longint'($signed(x)) : longint'({32'b0, x});
    sy  = sgn ? longint'($signed(y)) : longint'({32'b0, y});
    mdz = 1'b0;
    if (!o[0]) begin
      p  = sx * sy;
      mh = p[63:32];
      ml = p[31:0];
    end else if (y == 0) begin
      mh  = x;
      ml  = '1;
      mdz = 1'b1;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      mh = r[31:0];
      ml = q[31:0];
    end
  endfunction

  // Drive one start pulse. This returns at the negedge just after the
  // accepting edge, then scrambles the operands, since the unit must not reread them.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(3));
  endtask

  // Wait for done, counting edges after the accepting edge, which is count n0.
  // The wait is bounded: a missing done shows up as a latency miscompare.
  task automatic wait_done(input string name, input int n0);
    int n;
    n = n0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    check({name, " latency"}, 64'(n), 64'(W + 1));
    check({name, " busy at done"}, {63'b0, busy}, 64'd0);
  endtask

  initial begin
    int n;
    int ndone;
    logic [W-1:0] prev_hi, prev_lo;

    // Rows: op, a, b, expected hi, expected lo, expected div_zero.
    tbl[0]  = '{2'b00, 32'd7,          32'd6,          32'd0,          32'd42,         1'b0};
    tbl[1]  = '{2'b00, 32'hFFFFFFFF,   32'd2,          32'h00000001,   32'hFFFFFFFE,   1'b0};
    tbl[2]  = '{2'b01, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0};
    tbl[3]  = '{2'b01, 32'd5,          32'd0,          32'd5,          32'hFFFFFFFF,   1'b1};
    tbl[4]  = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001,   1'b0};
    tbl[5]  = '{2'b00, 32'd0,          32'h12345678,   32'd0,          32'd0,          1'b0};
    tbl[6]  = '{2'b01, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    tbl[7]  = '{2'b01, 32'd6,          32'd7,          32'd6,          32'd0,          1'b0};
    tbl[8]  = '{2'b01, 32'hFFFFFFFF,   32'd1,          32'd0,          32'hFFFFFFFF,   1'b0};
`ifdef MULDIV_SIGNED_EN
    tbl[9]  = '{2'b11, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   1'b0};
    tbl[10] = '{2'b11, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    tbl[11] = '{2'b10, 32'hFFFFFFF9,   32'd3,          32'hFFFFFFFF,   32'hFFFFFFEB,   1'b0};
`else
    tbl[9]  = '{2'b11, 32'hFFFFFFF9,   32'd2,          32'd1,          32'h7FFFFFFC,   1'b0};
    tbl[10] = '{2'b11, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    tbl[11] = '{2'b10, 32'hFFFFFFF9,   32'd3,          32'd2,          32'hFFFFFFEB,   1'b0};
`endif
    tbl[12] = '{2'b11, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   32'hFFFFFFFF,   1'b1};

    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {63'b0, busy}, 64'd0);
    check("reset done", {63'b0, done}, 64'd0);
    check("reset div_zero", {63'b0, div_zero}, 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    reset = 1'b0;

    // Directed table.
    prev_hi = '0; prev_lo = '0;
    for (int i = 0; i < NV; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      check($sformatf("v%0d busy after accept", i), {63'b0, busy}, 64'd1);
      check($sformatf("v%0d div_zero cleared", i), {63'b0, div_zero}, 64'd0);
      check($sformatf("v%0d hi held", i), 64'(hi), 64'(prev_hi));
      check($sformatf("v%0d lo held", i), 64'(lo), 64'(prev_lo));
      wait_done($sformatf("v%0d", i), 0);
      check($sformatf("v%0d hi", i), 64'(hi), 64'(tbl[i].hi));
      check($sformatf("v%0d lo", i), 64'(lo), 64'(tbl[i].lo));
      check($sformatf("v%0d div_zero", i), {63'b0, div_zero}, {63'b0, tbl[i].dz});
      @(negedge clk);
      check($sformatf("v%0d done one cycle", i), {63'b0, done}, 64'd0);
      prev_hi = tbl[i].hi; prev_lo = tbl[i].lo;
    end

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   o;
      logic [W-1:0] x, y, mh, ml;
      logic         mdz;
      o = 2'($urandom_range(3));
      x = $urandom;
      case ($urandom_range(3))
        0:       y = '0;
        1:       y = 32'($urandom_range(15));
        default: y = $urandom;
      endcase
      if ($urandom_range(3) == 0) x = 32'($urandom_range(1000));
      model(o, x, y, mh, ml, mdz);
      issue(o, x, y);
      wait_done($sformatf("rnd%0d", i), 0);
      check($sformatf("rnd%0d hi", i), 64'(hi), 64'(mh));
      check($sformatf("rnd%0d lo", i), 64'(lo), 64'(ml));
      check($sformatf("rnd%0d div_zero", i), {63'b0, div_zero}, {63'b0, mdz});
    end

    // A start pulsed at cycle 10 of a busy op is ignored and not queued.
    issue(2'b00, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored start", 10);
    check("ignored start lo", 64'(lo), 64'd15);
    check("ignored start hi", 64'(hi), 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("ignored start not queued", 64'(ndone), 64'd0);

    // A start held through the done cycle is accepted on the next edge.
    issue(2'b00, 32'd2, 32'd3);
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd50; b = 32'd5;
    wait_done("b2b first", 1);
    check("b2b first lo", 64'(lo), 64'd6);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("b2b second accepted", {63'b0, busy}, 64'd1);
        start = 1'b0;
      end
      if (done) break;
    end
    check("b2b done spacing", 64'(n), 64'(W + 2));
    check("b2b second lo", 64'(lo), 64'd10);
    check("b2b second hi", 64'(hi), 64'd0);

    // Reset during a div aborts it at once, and no done pulse follows.
    issue(2'b01, 32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid reset busy", {63'b0, busy}, 64'd0);
    check("mid reset hi", 64'(hi), 64'd0);
    check("mid reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no done after reset", 64'(ndone), 64'd0);
    issue(2'b00, 32'd3, 32'd4);
    wait_done("post reset mult", 0);
    check("post reset lo", 64'(lo), 64'd12);
    check("post reset hi", 64'(hi), 64'd0);

    // WIDTH=8 instance: 0xFF * 0xFF.
    @(negedge clk);
    start8 = 1'b1; op8 = 2'b00; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (done8) break;
    end
    check("w8 latency", 64'(n), 64'd9);
    check("w8 hi", 64'(hi8), 64'hFE);
    check("w8 lo", 64'(lo8), 64'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
